// File: rtl/axi_up_pkg.sv
// Register map, response codes and FSM state types shared by the
// user-plugin copy-engine configuration slave.
package axi_up_pkg;

  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_SIZE   = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_CMD    = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  localparam int CTRL_INT_EN_BIT = 0;
  localparam int CMD_TRIGGER_BIT = 1 - 1;
  localparam int CMD_CLR_INT_BIT = 1;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_INT_BIT  = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA} rd_state_t;

  // Byte-lane merge of a new write into the current register contents.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_bus.sv
// Minimal AXI4 bus bundle carrying the signals this slave consumes or drives.
interface AXI_BUS #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_USER_WIDTH = 1
);

  logic                        aw_valid;
  logic                        aw_ready;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [AXI_ID_WIDTH-1:0]     aw_id;

  logic                        w_valid;
  logic                        w_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;

  logic                        b_valid;
  logic                        b_ready;
  logic [1:0]                  b_resp;
  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [AXI_USER_WIDTH-1:0]   b_user;

  logic                        ar_valid;
  logic                        ar_ready;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [AXI_ID_WIDTH-1:0]     ar_id;

  logic                        r_valid;
  logic                        r_ready;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_USER_WIDTH-1:0]   r_user;

  modport Slave (
    input  aw_valid, aw_addr, aw_len, aw_id, output aw_ready,
    input  w_valid, w_data, w_strb, w_last, output w_ready,
    output b_valid, b_resp, b_id, b_user, input b_ready,
    input  ar_valid, ar_addr, ar_len, ar_id, output ar_ready,
    output r_valid, r_data, r_resp, r_last, r_id, r_user, input r_ready
  );

endinterface

// File: rtl/axi_up_regfile.sv
// Copy-engine register bank: storage with byte strobes, busy lock on the
// transfer parameters, command pulses and the read mux.
module axi_up_regfile
  import axi_up_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_WIDTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    wr_en,
  input  logic [2:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    wr_err,
  input  logic [2:0]              rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_err,
  input  logic                    status_busy_i,
  input  logic                    status_int_pending_i,
  output logic [ADDR_WIDTH-1:0]   src_addr_o,
  output logic [ADDR_WIDTH-1:0]   dst_addr_o,
  output logic [SIZE_WIDTH-1:0]   size_o,
  output logic                    ctrl_int_en_o,
  output logic                    cmd_trigger_pulse_o,
  output logic                    cmd_clr_int_pulse_o
);

  // Transfer parameters are frozen while the engine runs; CTRL/CMD stay live.
  always_comb begin
    wr_err = 1'b1;
    case (wr_addr)
      REG_SRC, REG_DST, REG_SIZE: wr_err = status_busy_i;
      REG_CTRL, REG_CMD:          wr_err = 1'b0;
      default:                    wr_err = 1'b1;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      src_addr_o          <= '0;
      dst_addr_o          <= '0;
      size_o              <= '0;
      ctrl_int_en_o       <= 1'b0;
      cmd_trigger_pulse_o <= 1'b0;
      cmd_clr_int_pulse_o <= 1'b0;
    end else begin
      if (wr_en && !wr_err && wr_addr == REG_SRC)
        src_addr_o <= strb_merge(src_addr_o, wr_data, wr_strb);
      if (wr_en && !wr_err && wr_addr == REG_DST)
        dst_addr_o <= strb_merge(dst_addr_o, wr_data, wr_strb);
      if (wr_en && !wr_err && wr_addr == REG_SIZE) begin
        for (int i = 0; i < SIZE_WIDTH; i++) begin
          if (wr_strb[i/8]) size_o[i] <= wr_data[i];
        end
      end
      if (wr_en && wr_addr == REG_CTRL && wr_strb[0])
        ctrl_int_en_o <= wr_data[CTRL_INT_EN_BIT];
      cmd_trigger_pulse_o <= wr_en && wr_addr == REG_CMD && wr_strb[0] && wr_data[CMD_TRIGGER_BIT];
      cmd_clr_int_pulse_o <= wr_en && wr_addr == REG_CMD && wr_strb[0] && wr_data[CMD_CLR_INT_BIT];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_addr)
      REG_SRC:  rd_data = src_addr_o;
      REG_DST:  rd_data = dst_addr_o;
      REG_SIZE: rd_data[SIZE_WIDTH-1:0] = size_o;
      REG_CTRL: rd_data[CTRL_INT_EN_BIT] = ctrl_int_en_o;
      REG_CMD:  rd_data = '0;
      REG_STATUS: begin
        rd_data[STATUS_BUSY_BIT] = status_busy_i;
        rd_data[STATUS_INT_BIT]  = status_int_pending_i;
      end
      default:  rd_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi_up_cfg_slv.sv
// AXI4 slave front end for the copy-engine register bank: independent
// write and read channel FSMs, INCR bursts handled one word per beat.
module axi_up_cfg_slv
  import axi_up_pkg::*;
#(
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 32,
  parameter int AXI4_ID_WIDTH   = 10,
  parameter int AXI4_USER_WIDTH = 1,
  parameter int REG_SIZE_WIDTH  = 16
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  AXI_BUS.Slave                      slv,
  output logic [AXI4_ADDR_WIDTH-1:0] src_addr_o,
  output logic [AXI4_ADDR_WIDTH-1:0] dst_addr_o,
  output logic [REG_SIZE_WIDTH-1:0]  size_o,
  output logic                       ctrl_int_en_o,
  output logic                       cmd_trigger_pulse_o,
  output logic                       cmd_clr_int_pulse_o,
  input  logic                       status_busy_i,
  input  logic                       status_int_pending_i
);

  wr_state_t                  wr_state_q, wr_state_d;
  rd_state_t                  rd_state_q, rd_state_d;
  logic [AXI4_ID_WIDTH-1:0]   aw_id_q, r_id_q;
  logic [2:0]                 wr_addr_q, rd_addr_q, rd_addr_sel;
  logic                       wr_err_q, wr_en, beat_err;
  logic [7:0]                 rd_len_q, rd_cnt_q;
  logic [AXI4_DATA_WIDTH-1:0] r_data_q, rd_data;
  logic [1:0]                 r_resp_q;
  logic                       r_last_q, rd_err, ar_hs, r_hs;
  logic                       unused_addr_bits;

  // Only the word index selects a register; the interconnect decodes the rest.
  assign unused_addr_bits = ^{slv.aw_addr[AXI4_ADDR_WIDTH-1:5], slv.aw_addr[1:0],
                              slv.ar_addr[AXI4_ADDR_WIDTH-1:5], slv.ar_addr[1:0], slv.aw_len};

  always_comb begin
    wr_state_d   = wr_state_q;
    slv.aw_ready = 1'b0;
    slv.w_ready  = 1'b0;
    slv.b_valid  = 1'b0;
    wr_en        = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        slv.aw_ready = 1'b1;
        if (slv.aw_valid) wr_state_d = W_DATA;
      end
      W_DATA: begin
        slv.w_ready = 1'b1;
        wr_en       = slv.w_valid;
        if (slv.w_valid && slv.w_last) wr_state_d = W_RESP;
      end
      W_RESP: begin
        slv.b_valid = 1'b1;
        if (slv.b_ready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state_q <= W_IDLE;
      aw_id_q    <= '0;
      wr_addr_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      if (wr_state_q == W_IDLE && slv.aw_valid) begin
        aw_id_q   <= slv.aw_id;
        wr_addr_q <= slv.aw_addr[4:2];
        wr_err_q  <= 1'b0;
      end
      if (wr_en) begin
        wr_addr_q <= wr_addr_q + 3'd1;
        wr_err_q  <= wr_err_q | beat_err;
      end
    end
  end

  assign slv.b_resp = wr_err_q ? RESP_SLVERR : RESP_OKAY;
  assign slv.b_id   = aw_id_q;
  assign slv.b_user = '0;

  assign ar_hs = slv.ar_valid && rd_state_q == R_IDLE;
  assign r_hs  = slv.r_ready && rd_state_q == R_DATA;

  always_comb begin
    rd_state_d   = rd_state_q;
    slv.ar_ready = 1'b0;
    slv.r_valid  = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        slv.ar_ready = 1'b1;
        if (slv.ar_valid) rd_state_d = R_DATA;
      end
      R_DATA: begin
        slv.r_valid = 1'b1;
        if (slv.r_ready && r_last_q) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // The mux looks one word ahead so each beat is registered when loaded.
  assign rd_addr_sel = (rd_state_q == R_IDLE) ? slv.ar_addr[4:2] : rd_addr_q + 3'd1;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      r_id_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
      r_last_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      if (ar_hs) begin
        rd_addr_q <= slv.ar_addr[4:2];
        rd_len_q  <= slv.ar_len;
        rd_cnt_q  <= '0;
        r_id_q    <= slv.ar_id;
        r_data_q  <= rd_data;
        r_resp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        r_last_q  <= (slv.ar_len == 8'd0);
      end else if (r_hs && !r_last_q) begin
        rd_addr_q <= rd_addr_sel;
        rd_cnt_q  <= rd_cnt_q + 8'd1;
        r_data_q  <= rd_data;
        r_resp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        r_last_q  <= (rd_cnt_q + 8'd1 == rd_len_q);
      end
    end
  end

  assign slv.r_data = r_data_q;
  assign slv.r_resp = r_resp_q;
  assign slv.r_last = r_last_q;
  assign slv.r_id   = r_id_q;
  assign slv.r_user = '0;

  axi_up_regfile #(
    .ADDR_WIDTH (AXI4_ADDR_WIDTH),
    .DATA_WIDTH (AXI4_DATA_WIDTH),
    .SIZE_WIDTH (REG_SIZE_WIDTH)
  ) u_regfile (
    .ACLK                 (ACLK),
    .ARESETn              (ARESETn),
    .wr_en                (wr_en),
    .wr_addr              (wr_addr_q),
    .wr_data              (slv.w_data),
    .wr_strb              (slv.w_strb),
    .wr_err               (beat_err),
    .rd_addr              (rd_addr_sel),
    .rd_data              (rd_data),
    .rd_err               (rd_err),
    .status_busy_i        (status_busy_i),
    .status_int_pending_i (status_int_pending_i),
    .src_addr_o           (src_addr_o),
    .dst_addr_o           (dst_addr_o),
    .size_o               (size_o),
    .ctrl_int_en_o        (ctrl_int_en_o),
    .cmd_trigger_pulse_o  (cmd_trigger_pulse_o),
    .cmd_clr_int_pulse_o  (cmd_clr_int_pulse_o)
  );

endmodule

// File: tb/tb_axi_up_cfg_slv.sv
// Scoreboard bench for axi_up_cfg_slv: directed AXI writes/reads push expected
// B/R responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_axi_up_cfg_slv;

  localparam int TIMEOUT = 50;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct {
    logic [1:0] resp;
    logic [9:0] id;
  } b_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [9:0]  id;
  } r_exp_t;

  logic        ACLK;
  logic        ARESETn;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] size_val;
  logic        ctrl_int_en, trig_pulse, clr_pulse;
  logic        status_busy, status_int_pending;

  int checks   = 0;
  int failures = 0;

  b_exp_t bq[$];
  r_exp_t rq[$];

  logic   held_valid = 1'b0;
  r_exp_t held;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(1)) slv_if ();

  axi_up_cfg_slv #(
    .AXI4_ADDR_WIDTH (32),
    .AXI4_DATA_WIDTH (32),
    .AXI4_ID_WIDTH   (10),
    .AXI4_USER_WIDTH (1),
    .REG_SIZE_WIDTH  (16)
  ) dut (
    .ACLK                 (ACLK),
    .ARESETn              (ARESETn),
    .slv                  (slv_if),
    .src_addr_o           (src_addr),
    .dst_addr_o           (dst_addr),
    .size_o               (size_val),
    .ctrl_int_en_o        (ctrl_int_en),
    .cmd_trigger_pulse_o  (trig_pulse),
    .cmd_clr_int_pulse_o  (clr_pulse),
    .status_busy_i        (status_busy),
    .status_int_pending_i (status_int_pending)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out after %0d cycles", name, TIMEOUT);
  endtask

  task automatic push_r(input logic [31:0] data, input logic [1:0] resp, input logic last, input logic [9:0] id);
    rq.push_back('{data: data, resp: resp, last: last, id: id});
  endtask

  // Monitor: stall stability first, then pop-and-compare on each handshake.
  always @(negedge ACLK) begin
    if (held_valid && slv_if.r_valid) begin
      checkOutput("r_stable_data", slv_if.r_data, held.data);
      checkOutput("r_stable_resp", slv_if.r_resp, held.resp);
      checkOutput("r_stable_last", slv_if.r_last, held.last);
      checkOutput("r_stable_id", slv_if.r_id, held.id);
    end
    if (slv_if.b_valid && slv_if.b_ready) begin
      if (bq.size() == 0) begin
        timeout_fail("b_unexpected");
      end else begin
        b_exp_t be;
        be = bq.pop_front();
        checkOutput("b_resp", slv_if.b_resp, be.resp);
        checkOutput("b_id", slv_if.b_id, be.id);
      end
    end
    if (slv_if.r_valid && slv_if.r_ready) begin
      if (rq.size() == 0) begin
        timeout_fail("r_unexpected");
      end else begin
        r_exp_t re;
        re = rq.pop_front();
        checkOutput("r_data", slv_if.r_data, re.data);
        checkOutput("r_resp", slv_if.r_resp, re.resp);
        checkOutput("r_last", slv_if.r_last, re.last);
        checkOutput("r_id", slv_if.r_id, re.id);
      end
    end
    held_valid = slv_if.r_valid && !slv_if.r_ready;
    held = '{data: slv_if.r_data, resp: slv_if.r_resp, last: slv_if.r_last, id: slv_if.r_id};
  end

  task automatic axi_write(input logic [31:0] addr, input logic [9:0] id, input int beats,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [3:0] strb, input logic [1:0] exp_resp,
                           input logic exp_trig, input logic exp_clr);
    int n;
    bq.push_back('{resp: exp_resp, id: id});
    slv_if.aw_addr  = addr;
    slv_if.aw_id    = id;
    slv_if.aw_len   = 8'(beats - 1);
    slv_if.aw_valid = 1'b1;
    n = 0;
    while (slv_if.aw_ready !== 1'b1 && n < TIMEOUT) begin @(posedge ACLK); #1; n++; end
    if (n >= TIMEOUT) timeout_fail("aw_ready_wait");
    @(posedge ACLK); #1;
    slv_if.aw_valid = 1'b0;
    checkOutput("w_ready_latency", slv_if.w_ready, 1);
    for (int b = 0; b < beats; b++) begin
      slv_if.w_data  = (b == 0) ? d0 : (b == 1) ? d1 : d2;
      slv_if.w_strb  = strb;
      slv_if.w_last  = (b == beats - 1);
      slv_if.w_valid = 1'b1;
      n = 0;
      while (slv_if.w_ready !== 1'b1 && n < TIMEOUT) begin @(posedge ACLK); #1; n++; end
      if (n >= TIMEOUT) timeout_fail("w_ready_wait");
      @(posedge ACLK); #1;
    end
    slv_if.w_valid = 1'b0;
    slv_if.w_last  = 1'b0;
    checkOutput("b_valid_latency", slv_if.b_valid, 1);
    checkOutput("trigger_pulse", trig_pulse, exp_trig);
    checkOutput("clr_int_pulse", clr_pulse, exp_clr);
    @(posedge ACLK); #1;
    checkOutput("trigger_pulse_end", trig_pulse, 0);
    checkOutput("clr_int_pulse_end", clr_pulse, 0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [9:0] id, input logic [7:0] len, input logic toggle);
    int n;
    int beats;
    slv_if.ar_addr  = addr;
    slv_if.ar_id    = id;
    slv_if.ar_len   = len;
    slv_if.ar_valid = 1'b1;
    n = 0;
    while (slv_if.ar_ready !== 1'b1 && n < TIMEOUT) begin @(posedge ACLK); #1; n++; end
    if (n >= TIMEOUT) timeout_fail("ar_ready_wait");
    @(posedge ACLK); #1;
    slv_if.ar_valid = 1'b0;
    checkOutput("r_valid_latency", slv_if.r_valid, 1);
    beats = 0;
    n = 0;
    while (beats < int'(len) + 1 && n < TIMEOUT) begin
      @(negedge ACLK);
      if (slv_if.r_valid && slv_if.r_ready) beats++;
      @(posedge ACLK); #1;
      if (toggle) slv_if.r_ready = ~slv_if.r_ready;
      n++;
    end
    if (n >= TIMEOUT) timeout_fail("r_beats_wait");
    slv_if.r_ready = 1'b1;
  endtask

  task automatic applyStimulus();
    int n;
    axi_write(32'h00, 10'h001, 1, 32'h1000_0000, 0, 0, 4'hF, OKAY, 0, 0);
    checkOutput("src_addr_o", src_addr, 32'h1000_0000);
    axi_write(32'h04, 10'h002, 1, 32'h2000_0000, 0, 0, 4'hF, OKAY, 0, 0);
    checkOutput("dst_addr_o", dst_addr, 32'h2000_0000);
    axi_write(32'h08, 10'h003, 1, 32'h0000_0040, 0, 0, 4'hF, OKAY, 0, 0);
    checkOutput("size_o", size_val, 16'h0040);
    push_r(32'h1000_0000, OKAY, 1, 10'h011); axi_read(32'h00, 10'h011, 8'd0, 1'b0);
    push_r(32'h2000_0000, OKAY, 1, 10'h012); axi_read(32'h04, 10'h012, 8'd0, 1'b0);
    push_r(32'h0000_0040, OKAY, 1, 10'h013); axi_read(32'h08, 10'h013, 8'd0, 1'b0);

    axi_write(32'h10, 10'h004, 1, 32'h1, 0, 0, 4'hF, OKAY, 1, 0);
    push_r(32'h0, OKAY, 1, 10'h014); axi_read(32'h10, 10'h014, 8'd0, 1'b0);
    axi_write(32'h10, 10'h005, 1, 32'h3, 0, 0, 4'b0010, OKAY, 0, 0);

    axi_write(32'h00, 10'h006, 1, 32'h0, 0, 0, 4'hF, OKAY, 0, 0);
    axi_write(32'h00, 10'h007, 1, 32'hAABB_CCDD, 0, 0, 4'b0010, OKAY, 0, 0);
    checkOutput("src_strobe", src_addr, 32'h0000_CC00);
    push_r(32'h0000_CC00, OKAY, 1, 10'h015); axi_read(32'h00, 10'h015, 8'd0, 1'b0);

    status_busy = 1'b1;
    axi_write(32'h08, 10'h008, 1, 32'h80, 0, 0, 4'hF, SLVERR, 0, 0);
    checkOutput("size_locked", size_val, 16'h0040);
    axi_write(32'h0C, 10'h009, 1, 32'h1, 0, 0, 4'hF, OKAY, 0, 0);
    checkOutput("ctrl_int_en_o", ctrl_int_en, 1);
    axi_write(32'h10, 10'h00A, 1, 32'h3, 0, 0, 4'hF, OKAY, 1, 1);

    status_int_pending = 1'b1;
    push_r(32'h40, OKAY, 0, 10'h2A5);
    push_r(32'h1,  OKAY, 0, 10'h2A5);
    push_r(32'h0,  OKAY, 0, 10'h2A5);
    push_r(32'h3,  OKAY, 1, 10'h2A5);
    axi_read(32'h08, 10'h2A5, 8'd3, 1'b1);

    push_r(32'h0, SLVERR, 1, 10'h016); axi_read(32'h18, 10'h016, 8'd0, 1'b0);
    axi_write(32'h14, 10'h00B, 1, 32'hFF, 0, 0, 4'hF, SLVERR, 0, 0);
    push_r(32'h0, SLVERR, 0, 10'h017);
    push_r(32'h0000_CC00, OKAY, 1, 10'h017);
    axi_read(32'h1C, 10'h017, 8'd1, 1'b0);

    status_busy = 1'b0;
    status_int_pending = 1'b0;
    axi_write(32'h00, 10'h00C, 2, 32'h1111_1111, 32'h2222_2222, 0, 4'hF, OKAY, 0, 0);
    checkOutput("burst_src", src_addr, 32'h1111_1111);
    checkOutput("burst_dst", dst_addr, 32'h2222_2222);
    axi_write(32'h10, 10'h00D, 2, 32'h0, 32'hFFFF_FFFF, 0, 4'hF, SLVERR, 0, 0);

    // Abort a 3-beat write after its first beat.
    slv_if.aw_addr  = 32'h00;
    slv_if.aw_id    = 10'h00E;
    slv_if.aw_len   = 8'd2;
    slv_if.aw_valid = 1'b1;
    checkOutput("aw_ready_idle", slv_if.aw_ready, 1);
    @(posedge ACLK); #1;
    slv_if.aw_valid = 1'b0;
    slv_if.w_data   = 32'hDEAD_BEEF;
    slv_if.w_strb   = 4'hF;
    slv_if.w_last   = 1'b0;
    slv_if.w_valid  = 1'b1;
    @(posedge ACLK); #1;
    checkOutput("src_mid_burst", src_addr, 32'hDEAD_BEEF);
    ARESETn = 1'b0;
    slv_if.w_valid = 1'b0;
    #2;
    checkOutput("src_async_reset", src_addr, 0);
    repeat (2) @(posedge ACLK);
    @(negedge ACLK) ARESETn = 1'b1;
    @(posedge ACLK); #1;
    checkOutput("abort_aw_ready", slv_if.aw_ready, 1);
    checkOutput("abort_w_ready", slv_if.w_ready, 0);
    checkOutput("abort_b_valid", slv_if.b_valid, 0);
    checkOutput("abort_src", src_addr, 0);
    checkOutput("abort_dst", dst_addr, 0);
    checkOutput("abort_size", size_val, 0);
    checkOutput("abort_ctrl", ctrl_int_en, 0);
    n = 0;
    repeat (3) begin @(posedge ACLK); #1; if (slv_if.b_valid) n++; end
    checkOutput("abort_no_b", n, 0);

    axi_write(32'h04, 10'h00F, 1, 32'h5A5A_5A5A, 0, 0, 4'hF, OKAY, 0, 0);
    push_r(32'h5A5A_5A5A, OKAY, 1, 10'h018); axi_read(32'h04, 10'h018, 8'd0, 1'b0);
  endtask

  initial begin
    ARESETn            = 1'b0;
    status_busy        = 1'b0;
    status_int_pending = 1'b0;
    slv_if.aw_valid = 1'b0; slv_if.aw_addr = '0; slv_if.aw_len = '0; slv_if.aw_id = '0;
    slv_if.w_valid  = 1'b0; slv_if.w_data  = '0; slv_if.w_strb = '0; slv_if.w_last = 1'b0;
    slv_if.ar_valid = 1'b0; slv_if.ar_addr = '0; slv_if.ar_len = '0; slv_if.ar_id = '0;
    slv_if.b_ready  = 1'b1;
    slv_if.r_ready  = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    checkOutput("rst_aw_ready", slv_if.aw_ready, 1);
    checkOutput("rst_ar_ready", slv_if.ar_ready, 1);
    checkOutput("rst_w_ready", slv_if.w_ready, 0);
    checkOutput("rst_b_valid", slv_if.b_valid, 0);
    checkOutput("rst_r_valid", slv_if.r_valid, 0);
    checkOutput("rst_b_resp", slv_if.b_resp, 0);
    checkOutput("rst_r_data", slv_if.r_data, 0);
    checkOutput("rst_src", src_addr, 0);
    checkOutput("rst_size", size_val, 0);
    checkOutput("rst_pulses", {trig_pulse, clr_pulse}, 0);
    @(negedge ACLK) ARESETn = 1'b1;
    applyStimulus();
    repeat (5) @(posedge ACLK);
    checkOutput("b_queue_drained", bq.size(), 0);
    checkOutput("r_queue_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axi_up_cfg_slv.md
# axi_up_cfg_slv

AXI4 slave that exposes the user-plugin copy engine's configuration and status as a memory-mapped register bank. Sits between the SoC AXI interconnect and `axi_up_ctrl`. It drives the engine's `src_addr_i`/`dst_addr_i`/`size_i`/`ctrl_int_en_i` and the one-cycle command pulses, and returns `status_busy_o`/`status_int_pending_o` on reads. Write and read channels are independent FSMs; INCR bursts are supported word by word.

## Interface
- AXI4_ADDR_WIDTH, 32, AXI address width
- AXI4_DATA_WIDTH, 32, AXI data width; only 32 is supported
- AXI4_ID_WIDTH, 10, AXI ID width
- AXI4_USER_WIDTH, 1, AXI user width
- REG_SIZE_WIDTH, 16, width of the SIZE register
- ACLK  in  1  clock
- ARESETn  in  1  reset, asynchronous, active-low
- slv  AXI_BUS.Slave  -  AXI4 slave port, all five channels
- src_addr_o  out  AXI4_ADDR_WIDTH  SRC_ADDR register
- dst_addr_o  out  AXI4_ADDR_WIDTH  DST_ADDR register
- size_o  out  REG_SIZE_WIDTH  SIZE register
- ctrl_int_en_o  out  1  CTRL[0]
- cmd_trigger_pulse_o  out  1  one-cycle pulse on a write of CMD[0]=1
- cmd_clr_int_pulse_o  out  1  one-cycle pulse on a write of CMD[1]=1
- status_busy_i  in  1  engine busy
- status_int_pending_i  in  1  engine interrupt pending

## Operation
- Decode uses addr[4:2]:
  - 0x00 SRC_ADDR (RW)
  - 0x04 DST_ADDR (RW)
  - 0x08 SIZE (RW, bits [REG_SIZE_WIDTH-1:0])
  - 0x0C CTRL (RW, bit0)
  - 0x10 CMD (WO, reads 0)
  - 0x14 STATUS (RO: bit0 busy, bit1 int_pending)
  - 0x18/0x1C unmapped.
- Bits above addr[4] are ignored; the interconnect selects the slave.
- Writes to RW registers honour w_strb per byte. CMD acts only if w_strb[0]=1.
- While status_busy_i=1, writes to SRC/DST/SIZE are dropped and return SLVERR. CTRL and CMD writes still apply.
- A write to STATUS is dropped and returns SLVERR.
- Any access to an unmapped address returns SLVERR; reads of unmapped addresses return data 0.
- For a multi-beat write, b_resp = SLVERR if any beat erred, otherwise OKAY.
- Write FSM:
  - W_IDLE: aw_ready=1. On handshake, capture id, word address and len, then go to W_DATA.
  - W_DATA: w_ready=1. Each beat writes the current word address, then the word address increments by 1 within the 3-bit field, wrapping 7→0. On w_last, go to W_RESP.
  - W_RESP: b_valid=1, held until b_ready, then go to W_IDLE.
- Read FSM:
  - R_IDLE: ar_ready=1. On handshake, capture id, word address and len, then go to R_DATA.
  - R_DATA: r_valid=1, with r_data/r_resp/r_last registered. r_last=1 when the beat counter equals len. On each r_ready handshake, advance the address; after the last beat, go to R_IDLE.
- Burst type is ignored; bursts are always treated as INCR. b_user/r_user are driven 0.

## Timing
- Reset: all registers 0, both FSMs idle.
  - aw_ready=ar_ready=1, w_ready=0, b_valid=r_valid=0.
  - Both pulses 0; b_resp/r_resp/r_data/r_last/b_id/r_id all 0.
- A write beat accepted in cycle N updates its register output at N+1. A CMD pulse is high for exactly cycle N+1.
- Write latency:
  - AW handshake in cycle N makes w_ready high from N+1.
  - A last W beat in cycle M gives b_valid at M+1.
  - A single write therefore needs at least 3 cycles per transaction, with no AW/W overlap.
- Read latency: AR handshake at N gives r_valid at N+1; each following beat appears 1 cycle after the previous beat's handshake.
- r_data, r_resp, r_last and r_id hold stable while r_valid=1 and r_ready=0. STATUS is sampled when the beat is loaded, not when it is accepted.
- A read and a write in the same cycle to the same register: the read returns the pre-write value.
- A trigger and a clr_int in the same CMD beat pulse both in the same cycle.
- ARESETn asserted mid-burst immediately aborts both FSMs to idle. No B/R response is issued for the aborted transaction.

## Structure
- Package axi_up_pkg holds:
  - register word offsets (REG_SRC=0 … REG_STATUS=5)
  - CTRL/CMD/STATUS bit positions
  - the wr_state_t {W_IDLE, W_DATA, W_RESP} and rd_state_t {R_IDLE, R_DATA} enums
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
- Sub-module axi_up_regfile contains the register storage, strobe merge, busy lock, pulse generation and the read mux (word address in, data/error out). The top level holds the two channel FSMs.

## Test plan
- Write 0x1000_0000 to 0x00, 0x2000_0000 to 0x04, 0x40 to 0x08, then read all three back → B OKAY each time; the reads return the same values and src_addr_o/dst_addr_o/size_o match.
- Write 0x1 to 0x10 → cmd_trigger_pulse_o high for exactly 1 cycle, one cycle after the W handshake; reading 0x10 returns 0.
- Write w_strb=4'b0010 with data 0xAABBCCDD to 0x00 holding 0 → the register reads 0x0000_CC00.
- Hold status_busy_i=1 and write to 0x08 → b_resp=SLVERR and size_o unchanged. Write 0x3 to 0x10 → both pulses fire in the same cycle.
- Issue a 4-beat INCR read at 0x08 with r_ready toggling 1,0,1 → data SIZE, CTRL, 0, STATUS; r_last only on beat 4; r_data stable across stalls; r_id echoes ar_id.
- Read 0x18 → r_resp=SLVERR with data 0. Assert ARESETn low in the middle of a 3-beat write → after release, aw_ready=1, b_valid=0 and all registers are 0.
